ahb_slv_ecc_mem_responder: RTL and testbench

Parametrised AHB-Lite-style slave responder for the bus testbench. It replaces the fixed counting read-data source with a word-addressed backing memory. Read data is returned as a SECDED Hamming codeword, with single- or double-bit error injection. It adds programmable wait states, an error-response address window, grant/master handling, and transfer counters for scoreboard checks.

---
 rtl/ahb_slv_ecc_mem_responder_if.sv | 28 ++
 rtl/ahb_slv_ecc_mem_responder.sv | 144 ++++++++++++++
 tb/tb_ahb_slv_ecc_mem_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_slv_ecc_mem_responder_if.sv
// AHB-Lite bus bundle between a master/testbench and the ECC memory responder.
interface ahb_slv_ecc_mem_responder_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [DATA_W-1:0] hwdata;
    logic              hbusreq;
    logic              hlock;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic [1:0]        hresp;
    logic              hgrant;
    logic [3:0]        hmaster;

    modport master (
        output haddr, htrans, hwrite, hsize, hburst, hwdata, hbusreq, hlock,
        input  hrdata, hready, hresp, hgrant, hmaster
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hburst, hwdata, hbusreq, hlock,
        output hrdata, hready, hresp, hgrant, hmaster
    );
endinterface

// File: rtl/ahb_slv_ecc_mem_responder.sv
// AHB-Lite slave responder backed by a word memory; reads return a SECDED
// Hamming codeword with optional bit-flip injection, wait states and an error window.
module ahb_slv_ecc_mem_responder #(
    parameter int          DATA_W      = 32,
    parameter int          K           = 26,
    parameter int          R           = 6,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ERR_BASE    = 32'hF000_0000,
    parameter logic [31:0] ERR_MASK    = 32'hF000_0000,
    parameter logic [3:0]  MASTER_ID   = 4'd1,
    parameter int          CNT_W       = 16
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    ahb_slv_ecc_mem_responder_if.slave bus,
    input  logic [5:0]                inj_pos_a,
    input  logic [5:0]                inj_pos_b,
    output logic [CNT_W-1:0]          rd_cnt,
    output logic [CNT_W-1:0]          wr_cnt,
    output logic [CNT_W-1:0]          err_cnt
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    logic [1:0]       state;
    logic [3:0]       wait_cnt;
    logic             dp_vld;
    logic             dp_write;
    logic [IDX_W-1:0] dp_idx;
    logic [K-1:0]     mem [MEM_DEPTH];

    logic ready;
    logic accept;
    logic hit;
    logic done;

    // IDLE and ERR2 are the only states that present hready=1
    assign ready  = (state == S_IDLE) || (state == S_ERR2);
    assign accept = ready && bus.htrans[1];
    assign hit    = (bus.haddr & ERR_MASK) == ERR_BASE;
    assign done   = dp_vld && ready;

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            dp_vld   <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) state <= S_IDLE;
                end
                S_ERR1: state <= S_ERR2;
                default: begin
                    if (accept && hit) begin
                        state <= S_ERR1;
                    end else if (accept && WAIT_CYCLES > 0) begin
                        state    <= S_WAIT;
                        wait_cnt <= 4'(WAIT_CYCLES);
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
            // error transfers never become an OKAY data phase
            if (accept) begin
                dp_vld   <= !hit;
                dp_write <= bus.hwrite;
                dp_idx   <= bus.haddr[2 +: IDX_W];
            end else if (ready) begin
                dp_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hresetn && done && dp_write) mem[dp_idx] <= bus.hwdata[K-1:0];
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            err_cnt     <= '0;
            bus.hgrant  <= 1'b0;
            bus.hmaster <= '0;
        end else begin
            if (done && !dp_write && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
            if (done && dp_write && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
            if (state == S_ERR1 && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            bus.hgrant <= bus.hbusreq;
            if (bus.hgrant && ready) bus.hmaster <= MASTER_ID;
        end
    end

    // Encoder: payload fills non-power-of-two positions in order, parity at powers of two
    function automatic logic [DATA_W-1:1] pmask(input int pos);
        logic [DATA_W-1:1] m;
        m = '0;
        for (int q = DATA_W - 1; q >= 1; q--)
            m = {m[DATA_W-2:1], (q & pos) != 0};
        return m;
    endfunction

    logic [K-1:0]      rd_word;
    logic [DATA_W-1:1] dpos;
    logic [DATA_W-1:1] ham;
    logic [DATA_W-1:0] code;
    logic [DATA_W-1:0] flip;

    assign rd_word = mem[dp_idx];

    for (genvar p = 1; p < DATA_W; p++) begin : g_pos
        if ((p & (p - 1)) == 0 && p < (1 << (R - 1))) begin : g_par
            assign dpos[p] = 1'b0;
            assign ham[p]  = ^(dpos & pmask(p));
        end else begin : g_dat
            assign dpos[p] = rd_word[p - $clog2(p + 1) - 1];
            assign ham[p]  = dpos[p];
        end
    end

    assign code = {^ham, ham};

    for (genvar p = 1; p <= DATA_W; p++) begin : g_flip
        assign flip[p-1] = (inj_pos_a == 6'(p)) ^ (inj_pos_b == 6'(p));
    end

    assign bus.hready = ready;
    assign bus.hresp  = (state == S_ERR1 || state == S_ERR2) ? 2'b01 : 2'b00;
    assign bus.hrdata = (done && !dp_write) ? (code ^ flip) : '0;

    logic unused_ok;
    assign unused_ok = ^{bus.hsize, bus.hburst, bus.hlock, bus.htrans[0],
                         bus.hwdata[DATA_W-1:K]};
endmodule

// File: tb/tb_ahb_slv_ecc_mem_responder.sv
// Directed bench: one zero-wait responder and one with three wait states.
module tb_ahb_slv_ecc_mem_responder;
    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic        rst_m, rst_w;
    logic [5:0]  inj_a_m, inj_b_m, inj_a_w, inj_b_w;
    logic [15:0] rd_m, wr_m, er_m, rd_w, wr_w, er_w;
    int          n_chk = 0;
    int          n_fail = 0;

    ahb_slv_ecc_mem_responder_if #(.DATA_W(32)) bm();
    ahb_slv_ecc_mem_responder_if #(.DATA_W(32)) bw();

    ahb_slv_ecc_mem_responder dut_m (
        .hclk(hclk), .hresetn(rst_m), .bus(bm),
        .inj_pos_a(inj_a_m), .inj_pos_b(inj_b_m),
        .rd_cnt(rd_m), .wr_cnt(wr_m), .err_cnt(er_m)
    );

    ahb_slv_ecc_mem_responder #(.WAIT_CYCLES(3)) dut_w (
        .hclk(hclk), .hresetn(rst_w), .bus(bw),
        .inj_pos_a(inj_a_w), .inj_pos_b(inj_b_w),
        .rd_cnt(rd_w), .wr_cnt(wr_w), .err_cnt(er_w)
    );

    // One transfer on the zero-wait instance; samples its single data phase
    task automatic m_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] rdata, output logic rdy, output logic [1:0] resp);
        bm.haddr = a; bm.hwrite = w; bm.htrans = 2'd2;
        @(posedge hclk); #1;
        bm.htrans = 2'd0; bm.hwdata = d;
        @(negedge hclk);
        rdata = bm.hrdata; rdy = bm.hready; resp = bm.hresp;
        @(posedge hclk); #1;
    endtask

    // One transfer on the wait-state instance; counts hready-low cycles, bounded
    task automatic w_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] rdata, output int low);
        bw.haddr = a; bw.hwrite = w; bw.htrans = 2'd2;
        @(posedge hclk); #1;
        bw.htrans = 2'd0; bw.hwdata = d;
        low = 0; rdata = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge hclk);
            if (bw.hready) begin
                rdata = bw.hrdata;
                break;
            end
            low++;
            @(posedge hclk); #1;
        end
        @(posedge hclk); #1;
    endtask

    task automatic test_reset();
        rst_m = 1'b0; rst_w = 1'b0;
        repeat (2) @(posedge hclk);
        #1; rst_m = 1'b1; rst_w = 1'b1;
        @(negedge hclk);
        n_chk++; if (bm.hready !== 1'b1) begin n_fail++; $display("FAIL reset_hready got=%0h exp=1", bm.hready); end
        n_chk++; if (bm.hresp !== 2'b00) begin n_fail++; $display("FAIL reset_hresp got=%0h exp=0", bm.hresp); end
        n_chk++; if (bm.hgrant !== 1'b0) begin n_fail++; $display("FAIL reset_hgrant got=%0h exp=0", bm.hgrant); end
        n_chk++; if (bm.hmaster !== 4'd0) begin n_fail++; $display("FAIL reset_hmaster got=%0h exp=0", bm.hmaster); end
        n_chk++; if (bm.hrdata !== 32'd0) begin n_fail++; $display("FAIL reset_hrdata got=%0h exp=0", bm.hrdata); end
        n_chk++; if ({rd_m, wr_m, er_m} !== 48'd0) begin n_fail++; $display("FAIL reset_counters got=%0h exp=0", {rd_m, wr_m, er_m}); end
        n_chk++; if (bw.hready !== 1'b1) begin n_fail++; $display("FAIL reset_w_hready got=%0h exp=1", bw.hready); end
        @(posedge hclk); #1;
    endtask

    task automatic test_basic_rw();
        logic [31:0] rd; logic rdy; logic [1:0] resp;
        m_xfer(32'h10, 1'b1, 32'h1, rd, rdy, resp);
        n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL wr_hready got=%0h exp=1", rdy); end
        n_chk++; if (rd !== 32'd0) begin n_fail++; $display("FAIL wr_hrdata got=%0h exp=0", rd); end
        n_chk++; if (wr_m !== 16'd1) begin n_fail++; $display("FAIL wr_cnt got=%0d exp=1", wr_m); end
        m_xfer(32'h10, 1'b0, 32'h0, rd, rdy, resp);
        n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL rd_hready got=%0h exp=1", rdy); end
        n_chk++; if (resp !== 2'b00) begin n_fail++; $display("FAIL rd_hresp got=%0h exp=0", resp); end
        n_chk++; if (rd !== 32'h8000_0007) begin n_fail++; $display("FAIL rd_data got=%0h exp=80000007", rd); end
        n_chk++; if (rd_m !== 16'd1) begin n_fail++; $display("FAIL rd_cnt got=%0d exp=1", rd_m); end
    endtask

    task automatic test_inject();
        logic [31:0] rd; logic rdy; logic [1:0] resp;
        inj_a_m = 6'd5; inj_b_m = 6'd0;
        m_xfer(32'h10, 1'b0, 32'h0, rd, rdy, resp);
        n_chk++; if (rd !== 32'h8000_0017) begin n_fail++; $display("FAIL inj_single got=%0h exp=80000017", rd); end
        inj_b_m = 6'd32;
        m_xfer(32'h10, 1'b0, 32'h0, rd, rdy, resp);
        n_chk++; if (rd !== 32'h0000_0017) begin n_fail++; $display("FAIL inj_double got=%0h exp=00000017", rd); end
        inj_b_m = 6'd5;
        m_xfer(32'h10, 1'b0, 32'h0, rd, rdy, resp);
        n_chk++; if (rd !== 32'h8000_0007) begin n_fail++; $display("FAIL inj_same got=%0h exp=80000007", rd); end
        inj_a_m = 6'd33; inj_b_m = 6'd0;
        m_xfer(32'h10, 1'b0, 32'h0, rd, rdy, resp);
        n_chk++; if (rd !== 32'h8000_0007) begin n_fail++; $display("FAIL inj_out_of_range got=%0h exp=80000007", rd); end
        inj_a_m = 6'd0;
        n_chk++; if (rd_m !== 16'd5) begin n_fail++; $display("FAIL inj_rd_cnt got=%0d exp=5", rd_m); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic rdy; logic [1:0] resp;
        m_xfer(32'h400, 1'b1, 32'h2, rd, rdy, resp);
        m_xfer(32'h0, 1'b0, 32'h0, rd, rdy, resp);
        n_chk++; if (rd !== 32'h8000_0019) begin n_fail++; $display("FAIL wrap_alias got=%0h exp=80000019", rd); end
        m_xfer(32'h10, 1'b0, 32'h0, rd, rdy, resp);
        n_chk++; if (rd !== 32'h8000_0007) begin n_fail++; $display("FAIL wrap_other got=%0h exp=80000007", rd); end
        n_chk++; if (wr_m !== 16'd2) begin n_fail++; $display("FAIL wrap_wr_cnt got=%0d exp=2", wr_m); end
    endtask

    task automatic test_err();
        logic [31:0] rd; logic rdy; logic [1:0] resp;
        bm.haddr = 32'hF000_0010; bm.hwrite = 1'b1; bm.htrans = 2'd2;
        @(posedge hclk); #1;
        bm.htrans = 2'd0; bm.hwdata = 32'hFF;
        @(negedge hclk);
        n_chk++; if ({bm.hready, bm.hresp} !== 3'b001) begin n_fail++; $display("FAIL err_cycle1 got=%0h exp=1", {bm.hready, bm.hresp}); end
        n_chk++; if (bm.hrdata !== 32'd0) begin n_fail++; $display("FAIL err_hrdata1 got=%0h exp=0", bm.hrdata); end
        @(posedge hclk); #1;
        @(negedge hclk);
        n_chk++; if ({bm.hready, bm.hresp} !== 3'b101) begin n_fail++; $display("FAIL err_cycle2 got=%0h exp=5", {bm.hready, bm.hresp}); end
        n_chk++; if (bm.hrdata !== 32'd0) begin n_fail++; $display("FAIL err_hrdata2 got=%0h exp=0", bm.hrdata); end
        @(posedge hclk); #1;
        @(negedge hclk);
        n_chk++; if ({bm.hready, bm.hresp} !== 3'b100) begin n_fail++; $display("FAIL err_after got=%0h exp=4", {bm.hready, bm.hresp}); end
        n_chk++; if (er_m !== 16'd1) begin n_fail++; $display("FAIL err_cnt got=%0d exp=1", er_m); end
        n_chk++; if (wr_m !== 16'd2) begin n_fail++; $display("FAIL err_wr_cnt got=%0d exp=2", wr_m); end
        @(posedge hclk); #1;
        m_xfer(32'h10, 1'b0, 32'h0, rd, rdy, resp);
        n_chk++; if (rd !== 32'h8000_0007) begin n_fail++; $display("FAIL err_mem_kept got=%0h exp=80000007", rd); end
    endtask

    task automatic test_pipelined_raw();
        bm.haddr = 32'h30; bm.hwrite = 1'b1; bm.htrans = 2'd2;
        @(posedge hclk); #1;
        bm.hwdata = 32'h3; bm.hwrite = 1'b0;
        @(negedge hclk);
        n_chk++; if (bm.hready !== 1'b1) begin n_fail++; $display("FAIL raw_wr_hready got=%0h exp=1", bm.hready); end
        @(posedge hclk); #1;
        bm.htrans = 2'd0;
        @(negedge hclk);
        n_chk++; if (bm.hrdata !== 32'h0000_001E) begin n_fail++; $display("FAIL raw_data got=%0h exp=1e", bm.hrdata); end
        @(posedge hclk); #1;
        n_chk++; if ({wr_m, rd_m} !== {16'd3, 16'd9}) begin n_fail++; $display("FAIL raw_counts got=%0h exp=30009", {wr_m, rd_m}); end
    endtask

    task automatic test_grant();
        logic [4:0] eg, em;
        eg = 5'b01110; em = 5'b11100;
        bm.hbusreq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge hclk);
            n_chk++; if (bm.hgrant !== eg[i]) begin n_fail++; $display("FAIL grant_%0d got=%0h exp=%0h", i, bm.hgrant, eg[i]); end
            n_chk++; if (bm.hmaster !== {3'd0, em[i]}) begin n_fail++; $display("FAIL master_%0d got=%0h exp=%0h", i, bm.hmaster, em[i]); end
            @(posedge hclk); #1;
            if (i == 2) bm.hbusreq = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int low;
        logic [31:0] exp_rd [8];
        logic [7:0]  exp_rdy;
        exp_rdy = 8'b1000_1000;
        exp_rd  = '{32'h0, 32'h0, 32'h0, 32'h8000_0007, 32'h0, 32'h0, 32'h0, 32'h8000_0019};
        w_xfer(32'h0, 1'b1, 32'h1, rd, low);
        n_chk++; if (low !== 3) begin n_fail++; $display("FAIL w_write_wait got=%0d exp=3", low); end
        w_xfer(32'h4, 1'b1, 32'h2, rd, low);
        bw.haddr = 32'h0; bw.hwrite = 1'b0; bw.htrans = 2'd2;
        @(posedge hclk); #1;
        bw.haddr = 32'h4;
        for (int i = 0; i < 8; i++) begin
            @(negedge hclk);
            n_chk++; if (bw.hready !== exp_rdy[i]) begin n_fail++; $display("FAIL b2b_hready_%0d got=%0h exp=%0h", i, bw.hready, exp_rdy[i]); end
            n_chk++; if (bw.hrdata !== exp_rd[i]) begin n_fail++; $display("FAIL b2b_hrdata_%0d got=%0h exp=%0h", i, bw.hrdata, exp_rd[i]); end
            @(posedge hclk); #1;
            if (i == 3) bw.htrans = 2'd0;
        end
        n_chk++; if ({rd_w, wr_w} !== {16'd2, 16'd2}) begin n_fail++; $display("FAIL b2b_counts got=%0h exp=20002", {rd_w, wr_w}); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int low;
        w_xfer(32'h20, 1'b1, 32'h1, rd, low);
        bw.haddr = 32'h20; bw.hwrite = 1'b1; bw.htrans = 2'd2;
        @(posedge hclk); #1;
        bw.htrans = 2'd0; bw.hwdata = 32'h2;
        @(negedge hclk);
        n_chk++; if (bw.hready !== 1'b0) begin n_fail++; $display("FAIL mid_in_wait got=%0h exp=0", bw.hready); end
        @(posedge hclk); #1;
        rst_w = 1'b0;
        @(posedge hclk); #1;
        rst_w = 1'b1;
        @(negedge hclk);
        n_chk++; if ({bw.hready, bw.hresp} !== 3'b100) begin n_fail++; $display("FAIL mid_ready_resp got=%0h exp=4", {bw.hready, bw.hresp}); end
        n_chk++; if ({rd_w, wr_w, er_w} !== 48'd0) begin n_fail++; $display("FAIL mid_counters got=%0h exp=0", {rd_w, wr_w, er_w}); end
        @(posedge hclk); #1;
        w_xfer(32'h20, 1'b0, 32'h0, rd, low);
        n_chk++; if (rd !== 32'h8000_0007) begin n_fail++; $display("FAIL mid_old_data got=%0h exp=80000007", rd); end
        n_chk++; if (low !== 3) begin n_fail++; $display("FAIL mid_read_wait got=%0d exp=3", low); end
        n_chk++; if (rd_w !== 16'd1) begin n_fail++; $display("FAIL mid_rd_cnt got=%0d exp=1", rd_w); end
    endtask

    initial begin
        rst_m = 1'b0; rst_w = 1'b0;
        inj_a_m = '0; inj_b_m = '0; inj_a_w = '0; inj_b_w = '0;
        bm.haddr = '0; bm.htrans = '0; bm.hwrite = 1'b0; bm.hsize = 3'd2; bm.hburst = '0;
        bm.hwdata = '0; bm.hbusreq = 1'b0; bm.hlock = 1'b0;
        bw.haddr = '0; bw.htrans = '0; bw.hwrite = 1'b0; bw.hsize = 3'd2; bw.hburst = '0;
        bw.hwdata = '0; bw.hbusreq = 1'b0; bw.hlock = 1'b0;
        test_reset();
        test_basic_rw();
        test_inject();
        test_wrap();
        test_err();
        test_pipelined_raw();
        test_grant();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
